// File: rtl/agn_burst_ctrl_if.sv
// Signal bundle between control logic, agn_burst_ctrl and the triangle generator.
// burst_cnt is present only when AGN_BURST_CNT_EN is defined.
interface agn_burst_ctrl_if;
  logic       start;
  logic       stop;
  logic       cont;
  logic [7:0] m_max;
  logic [7:0] step;
  logic [7:0] sustain_per;
  logic       up;
  logic       ce;
  logic [7:0] M;
  logic       busy;
  logic       done;
  logic [2:0] state;
`ifdef AGN_BURST_CNT_EN
  logic [15:0] burst_cnt;

  modport master (
    output start, stop, cont, m_max, step, sustain_per, up,
    input  ce, M, busy, done, state, burst_cnt
  );

  modport slave (
    input  start, stop, cont, m_max, step, sustain_per, up,
    output ce, M, busy, done, state, burst_cnt
  );
`else
  modport master (
    output start, stop, cont, m_max, step, sustain_per, up,
    input  ce, M, busy, done, state
  );

  modport slave (
    input  start, stop, cont, m_max, step, sustain_per, up,
    output ce, M, busy, done, state
  );
`endif
endinterface

// File: rtl/agn_burst_ctrl.sv
// Burst envelope sequencer for the triangle generator: ce prescaler plus period-synchronous
// attack/sustain/release/gap amplitude FSM. Optional completed-burst counter: AGN_BURST_CNT_EN.
module agn_burst_ctrl #(
  parameter int CE_DIV  = 4,
  parameter int GAP_PER = 2
) (
  input logic             clk,
  input logic             rst,
  agn_burst_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_SUSTAIN = 3'd2,
    S_RELEASE = 3'd3,
    S_GAP     = 3'd4
  } state_e;

  localparam int            PW       = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CE_DIV - 1);
  localparam logic [7:0]    GAP_CNT  = 8'(GAP_PER);

  logic [PW-1:0] pre_q;
  logic          ce_q;
  logic          up_dly_q;

  state_e     state_q, state_d;
  logic [7:0] m_q, m_d;
  logic [7:0] cnt_q, cnt_d;
  logic       stop_seen_q, stop_seen_d;
  logic       done_q, done_d;

  logic       pb;
  logic [7:0] step_e;
  logic [8:0] sum_up;
  logic [7:0] m_up;
  logic [7:0] m_dn;

  // Prescaler and UP edge detector run regardless of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q    <= '0;
      ce_q     <= 1'b0;
      up_dly_q <= 1'b1;
    end else begin
      ce_q     <= (pre_q == PRE_LAST);
      pre_q    <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      up_dly_q <= bus.up;
    end
  end

  assign pb     = bus.up & ~up_dly_q;
  assign step_e = (bus.step == 8'd0) ? 8'd1 : bus.step;
  assign sum_up = {1'b0, m_q} + {1'b0, step_e};
  assign m_up   = (sum_up >= {1'b0, bus.m_max}) ? bus.m_max : sum_up[7:0];
  assign m_dn   = (m_q > step_e) ? (m_q - step_e) : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      m_q         <= 8'd0;
      cnt_q       <= 8'd0;
      stop_seen_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      stop_seen_q <= stop_seen_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    cnt_d       = cnt_q;
    stop_seen_d = stop_seen_q | bus.stop;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stop_seen_d = 1'b0;
        m_d         = 8'd0;
        if (bus.start && !bus.stop) state_d = S_ATTACK;
      end
      S_ATTACK: begin
        // An abort keeps the partially ramped amplitude and releases from there.
        if (bus.stop) begin
          state_d = S_RELEASE;
        end else if (pb) begin
          m_d = m_up;
          if (m_up == bus.m_max) begin
            state_d = S_SUSTAIN;
            cnt_d   = bus.sustain_per;
          end
        end
      end
      S_SUSTAIN: begin
        if (bus.stop) begin
          state_d = S_RELEASE;
        end else if (pb) begin
          if (cnt_q == 8'd0) state_d = S_RELEASE;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      S_RELEASE: begin
        if (pb) begin
          m_d = m_dn;
          if (m_dn == 8'd0) begin
            done_d = 1'b1;
            if (bus.cont && !stop_seen_d) begin
              state_d = S_GAP;
              cnt_d   = GAP_CNT;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_GAP: begin
        m_d = 8'd0;
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (pb) begin
          if (cnt_q == 8'd0) state_d = S_ATTACK;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        m_d     = 8'd0;
      end
    endcase
  end

`ifdef AGN_BURST_CNT_EN
  logic [15:0] burst_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)         burst_cnt_q <= 16'd0;
    else if (done_d) burst_cnt_q <= burst_cnt_q + 16'd1;
  end

  assign bus.burst_cnt = burst_cnt_q;
`endif

  assign bus.ce    = ce_q;
  assign bus.M     = m_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_agn_burst_ctrl.sv
// Scoreboard bench for agn_burst_ctrl: stimulus queues hand-computed envelope events,
// a negedge monitor pops one per observed state/M change or done pulse.
module tb_agn_burst_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  agn_burst_ctrl_if bus ();

  agn_burst_ctrl #(
    .CE_DIV  (4),
    .GAP_PER (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [2:0] state;
    logic [7:0] m;
    logic       done;
  } obs_t;

  obs_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   done_seen = 0;
  int   done_exp  = 0;
  bit   mon_en    = 1'b0;
  logic [2:0] prev_state;
  logic [7:0] prev_m;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic expect_ev(input logic [2:0] s, input logic [7:0] m, input logic d);
    obs_t o;
    o.busy  = (s != 3'd0);
    o.state = s;
    o.m     = m;
    o.done  = d;
    exp_q.push_back(o);
    if (d) done_exp++;
  endtask

  // Monitor: any change of state or M, or a done pulse, is one transaction.
  always @(negedge clk) begin
    obs_t act_o;
    obs_t exp_o;
    act_o.busy  = bus.busy;
    act_o.state = bus.state;
    act_o.m     = bus.M;
    act_o.done  = bus.done;
    if (mon_en) begin
      if (bus.done) done_seen++;
      if (bus.state != prev_state || bus.M != prev_m || bus.done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event actual=busy%0d/st%0d/M%0d/done%0d required=no_event t=%0t",
                   act_o.busy, act_o.state, act_o.m, act_o.done, $time);
        end else begin
          exp_o = exp_q.pop_front();
          if (act_o !== exp_o) begin
            failures++;
            $display("FAIL event actual=busy%0d/st%0d/M%0d/done%0d required=busy%0d/st%0d/M%0d/done%0d t=%0t",
                     act_o.busy, act_o.state, act_o.m, act_o.done,
                     exp_o.busy, exp_o.state, exp_o.m, exp_o.done, $time);
          end else begin
            $display("ok   event busy%0d/st%0d/M%0d/done%0d t=%0t",
                     act_o.busy, act_o.state, act_o.m, act_o.done, $time);
          end
        end
      end
    end
    prev_state = bus.state;
    prev_m     = bus.M;
  end

  // All stimulus tasks are entered and left on a negedge.
  task automatic pulse_pb();
    bus.up = 1'b0;
    @(negedge clk);
    bus.up = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic cfg(input logic c, input logic [7:0] mx, input logic [7:0] st, input logic [7:0] sp);
    bus.cont        = c;
    bus.m_max       = mx;
    bus.step        = st;
    bus.sustain_per = sp;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.up = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
    cfg(1'b0, 8'd0, 8'd0, 8'd0);

    // Reset and prescaler phase
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_M", bus.M, 0);
    chk("reset_state", bus.state, 0);
    chk("reset_ce", bus.ce, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
`ifdef AGN_BURST_CNT_EN
    chk("reset_burst_cnt", bus.burst_cnt, 0);
`endif
    rst    = 1'b0;
    mon_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("ce_clk%0d", k), bus.ce, (k % 4 == 0) ? 1 : 0);
    end

    // Single burst: 20,40,60,80, three sustain periods, 60,40,20,0
    cfg(1'b0, 8'd80, 8'd20, 8'd2);
    expect_ev(3'd1, 8'd0, 1'b0);  pulse_start();
    expect_ev(3'd1, 8'd20, 1'b0); pulse_pb();
    expect_ev(3'd1, 8'd40, 1'b0); pulse_pb();
    expect_ev(3'd1, 8'd60, 1'b0); pulse_pb();
    expect_ev(3'd2, 8'd80, 1'b0); pulse_pb();
    pulse_pb(); pulse_pb();
    expect_ev(3'd3, 8'd80, 1'b0); pulse_pb();
    expect_ev(3'd3, 8'd60, 1'b0); pulse_pb();
    expect_ev(3'd3, 8'd40, 1'b0); pulse_pb();
    expect_ev(3'd3, 8'd20, 1'b0); pulse_pb();
    expect_ev(3'd0, 8'd0, 1'b1);  pulse_pb();
    idle_clks(2);
    chk("single_busy_low", bus.busy, 0);

    // Saturation: 30 then clamped 50
    cfg(1'b0, 8'd50, 8'd30, 8'd0);
    expect_ev(3'd1, 8'd0, 1'b0);  pulse_start();
    expect_ev(3'd1, 8'd30, 1'b0); pulse_pb();
    expect_ev(3'd2, 8'd50, 1'b0); pulse_pb();
    expect_ev(3'd3, 8'd50, 1'b0); pulse_pb();
    expect_ev(3'd3, 8'd20, 1'b0); pulse_pb();
    expect_ev(3'd0, 8'd0, 1'b1);  pulse_pb();
    idle_clks(2);

    // Zero step behaves as step 1
    cfg(1'b0, 8'd3, 8'd0, 8'd0);
    expect_ev(3'd1, 8'd0, 1'b0); pulse_start();
    expect_ev(3'd1, 8'd1, 1'b0); pulse_pb();
    expect_ev(3'd1, 8'd2, 1'b0); pulse_pb();
    expect_ev(3'd2, 8'd3, 1'b0); pulse_pb();
    expect_ev(3'd3, 8'd3, 1'b0); pulse_pb();
    expect_ev(3'd3, 8'd2, 1'b0); pulse_pb();
    expect_ev(3'd3, 8'd1, 1'b0); pulse_pb();
    expect_ev(3'd0, 8'd0, 1'b1); pulse_pb();
    idle_clks(2);

    // Continuous: two bursts separated by a 3-period gap, then stop in GAP
    cfg(1'b1, 8'd40, 8'd20, 8'd0);
    expect_ev(3'd1, 8'd0, 1'b0); pulse_start();
    for (int b = 0; b < 2; b++) begin
      expect_ev(3'd1, 8'd20, 1'b0); pulse_pb();
      expect_ev(3'd2, 8'd40, 1'b0); pulse_pb();
      expect_ev(3'd3, 8'd40, 1'b0); pulse_pb();
      expect_ev(3'd3, 8'd20, 1'b0); pulse_pb();
      expect_ev(3'd4, 8'd0, 1'b1);  pulse_pb();
      if (b == 0) begin
        pulse_pb(); pulse_pb();
        expect_ev(3'd1, 8'd0, 1'b0); pulse_pb();
      end
    end
    idle_clks(1);
    chk("gap_state", bus.state, 4);
    expect_ev(3'd0, 8'd0, 1'b0); pulse_stop();
    idle_clks(2);

    // Abort from SUSTAIN with cont=1; start while busy is ignored
    cfg(1'b1, 8'd80, 8'd40, 8'd5);
    expect_ev(3'd1, 8'd0, 1'b0);  pulse_start();
    expect_ev(3'd1, 8'd40, 1'b0); pulse_pb();
    expect_ev(3'd2, 8'd80, 1'b0); pulse_pb();
    pulse_pb();
    expect_ev(3'd3, 8'd80, 1'b0); pulse_stop();
    pulse_start();
    idle_clks(1);
    chk("start_while_busy_state", bus.state, 3);
    expect_ev(3'd3, 8'd40, 1'b0); pulse_pb();
    expect_ev(3'd0, 8'd0, 1'b1);  pulse_pb();
    idle_clks(2);

    // start and stop together in IDLE: stop wins
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    idle_clks(2);
    chk("start_stop_idle_state", bus.state, 0);

    // m_max lowered below M during ATTACK clamps and enters SUSTAIN
    cfg(1'b0, 8'd100, 8'd30, 8'd0);
    expect_ev(3'd1, 8'd0, 1'b0);  pulse_start();
    expect_ev(3'd1, 8'd30, 1'b0); pulse_pb();
    expect_ev(3'd1, 8'd60, 1'b0); pulse_pb();
    bus.m_max = 8'd40;
    expect_ev(3'd2, 8'd40, 1'b0); pulse_pb();
    expect_ev(3'd3, 8'd40, 1'b0); pulse_pb();
    expect_ev(3'd3, 8'd10, 1'b0); pulse_pb();
    expect_ev(3'd0, 8'd0, 1'b1);  pulse_pb();
    idle_clks(2);
    chk("done_count", done_seen, done_exp);

    // Reset in the middle of ATTACK
    cfg(1'b0, 8'd80, 8'd20, 8'd0);
    expect_ev(3'd1, 8'd0, 1'b0);  pulse_start();
    expect_ev(3'd1, 8'd20, 1'b0); pulse_pb();
`ifdef AGN_BURST_CNT_EN
    chk("burst_cnt_before_rst", bus.burst_cnt, done_exp);
`endif
    expect_ev(3'd0, 8'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_M", bus.M, 0);
    chk("rst_mid_ce", bus.ce, 0);
`ifdef AGN_BURST_CNT_EN
    chk("burst_cnt_after_rst", bus.burst_cnt, 0);
`endif
    idle_clks(3);

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("done_count_final", done_seen, done_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
